// File: rtl/rx_data_link_layer.sv
// Receive-side data link layer: checks CHK and sequence number of each
// incoming link packet, returns ack/nack and forwards the three payload DWs
// of in-sequence packets to the transaction layer.
module rx_data_link_layer (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [127:0] tlp_data_in,
  input  logic         tlp_data_in_valid,
  output logic         tlp_data_in_ready,
  output logic         ack,
  output logic         nack,
  output logic [11:0]  ack_seq,
  output logic [31:0]  tlp_data_out,
  output logic         tlp_data_out_valid,
  input  logic         tlp_data_out_ready
);

  localparam int unsigned PKT_W   = 128;
  localparam int unsigned SEQ_W   = 12;
  localparam int unsigned DW_W    = 32;
  localparam int unsigned CHK_W   = 16;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned N_SLICE = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    SEND  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PKT_W-1:0]   pkt_q, pkt_d;
  logic [SEQ_W-1:0]   exp_seq_q, exp_seq_d;
  logic [SEQ_W-1:0]   ack_seq_q, ack_seq_d;
  logic               ack_q, ack_d;
  logic               nack_q, nack_d;
  logic [CNT_W-1:0]   dw_cnt_q, dw_cnt_d;
  logic [DW_W-1:0]    dout_q, dout_d;
  logic               dvalid_q, dvalid_d;
  logic               in_ready_q, in_ready_d;

  // XOR of the seven 16-bit slices covering [127:16]
  function automatic logic [CHK_W-1:0] calc_chk(input logic [PKT_W-1:0] p);
    logic [CHK_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(N_SLICE); i++) begin
      c = c ^ p[PKT_W-1-CHK_W*i -: CHK_W];
    end
    return c;
  endfunction

  logic [SEQ_W-1:0] pkt_seq;
  logic [SEQ_W-1:0] exp_seq_prev;
  logic [SEQ_W-1:0] exp_seq_next;
  logic             chk_ok;
  logic [DW_W-1:0]  pkt_dw0, pkt_dw1, pkt_dw2;

  // Field extraction and check terms for the captured packet
  always_comb begin
    pkt_seq      = pkt_q[127:116];
    pkt_dw0      = pkt_q[111:80];
    pkt_dw1      = pkt_q[79:48];
    pkt_dw2      = pkt_q[47:16];
    chk_ok       = (calc_chk(pkt_q) == pkt_q[CHK_W-1:0]);
    exp_seq_prev = SEQ_W'(exp_seq_q - SEQ_W'(1));
    exp_seq_next = SEQ_W'(exp_seq_q + SEQ_W'(1));
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pkt_q      <= '0;
      exp_seq_q  <= '0;
      ack_seq_q  <= '0;
      ack_q      <= 1'b0;
      nack_q     <= 1'b0;
      dw_cnt_q   <= '0;
      dout_q     <= '0;
      dvalid_q   <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      pkt_q      <= pkt_d;
      exp_seq_q  <= exp_seq_d;
      ack_seq_q  <= ack_seq_d;
      ack_q      <= ack_d;
      nack_q     <= nack_d;
      dw_cnt_q   <= dw_cnt_d;
      dout_q     <= dout_d;
      dvalid_q   <= dvalid_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Next-state, check result and DW sequencing
  always_comb begin
    state_d   = state_q;
    pkt_d     = pkt_q;
    exp_seq_d = exp_seq_q;
    ack_seq_d = ack_seq_q;
    ack_d     = 1'b0;
    nack_d    = 1'b0;
    dw_cnt_d  = dw_cnt_q;
    dout_d    = dout_q;
    dvalid_d  = dvalid_q;

    case (state_q)
      IDLE: begin
        if (tlp_data_in_valid) begin
          pkt_d   = tlp_data_in;
          state_d = CHECK;
        end
      end

      CHECK: begin
        if (chk_ok && (pkt_seq == exp_seq_q)) begin
          // In-sequence packet: acknowledge and start forwarding DW0
          ack_d     = 1'b1;
          ack_seq_d = pkt_seq;
          exp_seq_d = exp_seq_next;
          dw_cnt_d  = '0;
          dout_d    = pkt_dw0;
          dvalid_d  = 1'b1;
          state_d   = SEND;
        end else if (chk_ok && (pkt_seq == exp_seq_prev)) begin
          // Retransmitted copy of the last good packet: re-ack, drop payload
          ack_d     = 1'b1;
          ack_seq_d = pkt_seq;
          state_d   = IDLE;
        end else begin
          // Corrupt or out-of-order: report last good sequence number
          nack_d    = 1'b1;
          ack_seq_d = exp_seq_prev;
          state_d   = IDLE;
        end
      end

      SEND: begin
        if (dvalid_q && tlp_data_out_ready) begin
          case (dw_cnt_q)
            2'd0: begin
              dout_d   = pkt_dw1;
              dw_cnt_d = 2'd1;
            end
            2'd1: begin
              dout_d   = pkt_dw2;
              dw_cnt_d = 2'd2;
            end
            default: begin
              dvalid_d = 1'b0;
              dw_cnt_d = '0;
              state_d  = IDLE;
            end
          endcase
        end
      end

      default: begin
        state_d  = IDLE;
        dvalid_d = 1'b0;
      end
    endcase

    in_ready_d = (state_d == IDLE);
  end

  assign tlp_data_in_ready  = in_ready_q;
  assign ack                = ack_q;
  assign nack               = nack_q;
  assign ack_seq            = ack_seq_q;
  assign tlp_data_out       = dout_q;
  assign tlp_data_out_valid = dvalid_q;

endmodule

// File: tb/tb_rx_data_link_layer.sv
// Scoreboard bench for rx_data_link_layer: stimulus pushes expected ack/nack
// events and payload DWs; a negedge monitor pops and compares them.
module tb_rx_data_link_layer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [127:0] tlp_data_in;
  logic         tlp_data_in_valid;
  logic         tlp_data_in_ready;
  logic         ack;
  logic         nack;
  logic [11:0]  ack_seq;
  logic [31:0]  tlp_data_out;
  logic         tlp_data_out_valid;
  logic         tlp_data_out_ready;

  int tests  = 0;
  int errors = 0;

  typedef struct packed {
    logic        is_nack;
    logic [11:0] seq;
  } ev_t;

  ev_t         ev_q[$];
  logic [31:0] dw_q[$];

  rx_data_link_layer dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .tlp_data_in        (tlp_data_in),
    .tlp_data_in_valid  (tlp_data_in_valid),
    .tlp_data_in_ready  (tlp_data_in_ready),
    .ack                (ack),
    .nack               (nack),
    .ack_seq            (ack_seq),
    .tlp_data_out       (tlp_data_out),
    .tlp_data_out_valid (tlp_data_out_valid),
    .tlp_data_out_ready (tlp_data_out_ready)
  );

  always #5 clk = ~clk;

  // Packet builder; flip inverts CHK bit 0
  function automatic logic [127:0] mk_pkt(input logic [11:0] seq, input logic [31:0] d0,
                                          input logic [31:0] d1, input logic [31:0] d2,
                                          input logic flip);
    logic [127:0] p;
    logic [15:0]  c;
    p = {seq, 4'h5, d0, d1, d2, 16'h0000};
    c = 16'h0000;
    for (int i = 0; i < 7; i++) c = c ^ p[127-16*i -: 16];
    p[15:0] = c ^ {15'd0, flip};
    return p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input logic is_nack, input logic [11:0] seq);
    ev_t e;
    e.is_nack = is_nack;
    e.seq     = seq;
    ev_q.push_back(e);
  endtask

  task automatic push_dws(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    dw_q.push_back(d0);
    dw_q.push_back(d1);
    dw_q.push_back(d2);
  endtask

  // Present a packet until it is accepted; returns 1 ns after the handshake edge
  task automatic send_pkt(input logic [127:0] p);
    int n;
    tlp_data_in       = p;
    tlp_data_in_valid = 1'b1;
    n = 0;
    while (!tlp_data_in_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      tests++;
      errors++;
      $display("FAIL send_timeout: got ready=0, expected ready=1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    tlp_data_in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    step();
    while (!tlp_data_in_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      tests++;
      errors++;
      $display("FAIL idle_timeout: got ready=0, expected ready=1 within 50 cycles");
    end
  endtask

  // Monitor: compare every ack/nack pulse and accepted DW against the scoreboard
  always @(negedge clk) begin
    if (reset_n) begin
      if (ack || nack) begin
        tests++;
        if (ack && nack) begin
          errors++;
          $display("FAIL ack_nack_exclusive: got ack=1 nack=1, expected only one");
        end
        tests++;
        if (ev_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: got ack=%0b nack=%0b seq=%0d, expected no pulse",
                   ack, nack, ack_seq);
        end else begin
          ev_t e;
          e = ev_q.pop_front();
          if (e.is_nack !== nack || e.seq !== ack_seq) begin
            errors++;
            $display("FAIL ack_event: got nack=%0b seq=%0d, expected nack=%0b seq=%0d",
                     nack, ack_seq, e.is_nack, e.seq);
          end
        end
      end
      if (tlp_data_out_valid && tlp_data_out_ready) begin
        tests++;
        if (dw_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_dw: got 0x%0h, expected no DW", tlp_data_out);
        end else begin
          logic [31:0] d;
          d = dw_q.pop_front();
          if (d !== tlp_data_out) begin
            errors++;
            $display("FAIL dw_data: got 0x%0h, expected 0x%0h", tlp_data_out, d);
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish, expected finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] pa, pb;
    reset_n            = 1'b0;
    tlp_data_in        = '0;
    tlp_data_in_valid  = 1'b0;
    tlp_data_out_ready = 1'b1;
    step();
    step();

    // Reset state
    check("rst_in_ready", 32'(tlp_data_in_ready), 32'd1);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_nack", 32'(nack), 32'd0);
    check("rst_out_valid", 32'(tlp_data_out_valid), 32'd0);
    check("rst_out_data", tlp_data_out, 32'd0);
    check("rst_ack_seq", 32'(ack_seq), 32'd0);
    reset_n = 1'b1;
    step();

    // Good packet SEQ=0; CHK of this vector is 0x0000 by hand
    push_ev(1'b0, 12'd0);
    push_dws(32'h11111111, 32'h22222222, 32'h33333333);
    send_pkt(128'h000_0_11111111_22222222_33333333_0000);
    check("check_in_ready_low", 32'(tlp_data_in_ready), 32'd0);
    step();
    check("first_dw_ack", 32'(ack), 32'd1);
    check("first_dw_valid", 32'(tlp_data_out_valid), 32'd1);
    check("first_dw_data", tlp_data_out, 32'h11111111);
    step();
    check("second_dw_data", tlp_data_out, 32'h22222222);
    check("second_dw_ack_low", 32'(ack), 32'd0);
    step();
    check("third_dw_data", tlp_data_out, 32'h33333333);
    step();
    check("after_send_valid", 32'(tlp_data_out_valid), 32'd0);
    check("after_send_ready", 32'(tlp_data_in_ready), 32'd1);

    // CHK error on SEQ=1 (expected 1): nack with last good seq 0
    push_ev(1'b1, 12'd0);
    send_pkt(mk_pkt(12'd1, 32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003, 1'b1));
    wait_idle();

    // Duplicate SEQ=0 then out-of-order SEQ=5
    push_ev(1'b0, 12'd0);
    send_pkt(mk_pkt(12'd0, 32'hBBBB0001, 32'hBBBB0002, 32'hBBBB0003, 1'b0));
    wait_idle();
    push_ev(1'b1, 12'd0);
    send_pkt(mk_pkt(12'd5, 32'hCCCC0001, 32'hCCCC0002, 32'hCCCC0003, 1'b0));
    wait_idle();
    check("bad_no_valid", 32'(tlp_data_out_valid), 32'd0);

    // Backpressure on DW1 with the next packet waiting on the input
    pa = mk_pkt(12'd1, 32'hD0D00000, 32'hD1D10001, 32'hD2D20002, 1'b0);
    pb = mk_pkt(12'd2, 32'hE0E00000, 32'hE1E10001, 32'hE2E20002, 1'b0);
    push_ev(1'b0, 12'd1);
    push_dws(32'hD0D00000, 32'hD1D10001, 32'hD2D20002);
    send_pkt(pa);
    tlp_data_in       = pb;
    tlp_data_in_valid = 1'b1;
    step();
    step();
    tlp_data_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("bp_dw1_data", tlp_data_out, 32'hD1D10001);
      check("bp_dw1_valid", 32'(tlp_data_out_valid), 32'd1);
      check("bp_in_ready", 32'(tlp_data_in_ready), 32'd0);
      step();
    end
    tlp_data_out_ready = 1'b1;
    check("bp_dw1_held", tlp_data_out, 32'hD1D10001);
    push_ev(1'b0, 12'd2);
    push_dws(32'hE0E00000, 32'hE1E10001, 32'hE2E20002);
    step();
    check("bp_dw2_data", tlp_data_out, 32'hD2D20002);
    step();
    check("bp_idle_ready", 32'(tlp_data_in_ready), 32'd1);
    check("bp_idle_valid", 32'(tlp_data_out_valid), 32'd0);
    step();
    check("bp_next_accepted", 32'(tlp_data_in_ready), 32'd0);
    tlp_data_in_valid = 1'b0;
    wait_idle();

    // Walk expected_seq up to 4095, then wrap
    for (int s = 3; s <= 4095; s++) begin
      push_ev(1'b0, 12'(s));
      push_dws(32'hA0000000 | 32'(s), 32'hB0000000 | 32'(s), 32'hC0000000 | 32'(s));
      send_pkt(mk_pkt(12'(s), 32'hA0000000 | 32'(s), 32'hB0000000 | 32'(s),
                      32'hC0000000 | 32'(s), 1'b0));
      wait_idle();
    end
    push_ev(1'b0, 12'd4095);
    send_pkt(mk_pkt(12'd4095, 32'h0F0F0F0F, 32'h1F1F1F1F, 32'h2F2F2F2F, 1'b0));
    wait_idle();
    push_ev(1'b0, 12'd0);
    push_dws(32'h12345678, 32'h9ABCDEF0, 32'h0BADF00D);
    send_pkt(mk_pkt(12'd0, 32'h12345678, 32'h9ABCDEF0, 32'h0BADF00D, 1'b0));
    wait_idle();
    push_ev(1'b1, 12'd0);
    send_pkt(mk_pkt(12'd7, 32'h7, 32'h7, 32'h7, 1'b0));
    wait_idle();

    // Reset after DW0 of SEQ=1 is accepted
    push_ev(1'b0, 12'd1);
    push_dws(32'h5A5A0000, 32'h5A5A0001, 32'h5A5A0002);
    send_pkt(mk_pkt(12'd1, 32'h5A5A0000, 32'h5A5A0001, 32'h5A5A0002, 1'b0));
    step();
    step();
    reset_n = 1'b0;
    #1;
    check("rstmid_valid", 32'(tlp_data_out_valid), 32'd0);
    check("rstmid_ready", 32'(tlp_data_in_ready), 32'd1);
    check("rstmid_ack", 32'(ack), 32'd0);
    check("rstmid_nack", 32'(nack), 32'd0);
    check("rstmid_data", tlp_data_out, 32'd0);
    check("rstmid_pending_dws", 32'(dw_q.size()), 32'd2);
    dw_q.delete();
    step();
    step();
    reset_n = 1'b1;
    step();
    push_ev(1'b0, 12'd0);
    push_dws(32'h600D0000, 32'h600D0001, 32'h600D0002);
    send_pkt(mk_pkt(12'd0, 32'h600D0000, 32'h600D0001, 32'h600D0002, 1'b0));
    wait_idle();
    step();

    check("sb_events_drained", 32'(ev_q.size()), 32'd0);
    check("sb_dws_drained", 32'(dw_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
